// File: rtl/maze_dfs_solver_pkg.sv
// Shared definitions for the maze DFS solver: direction codes, FSM state
// encoding and the direction-reversal helper.
// No ports; imported by the interface, the top and the path stack.
package maze_dfs_solver_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_DOWN  = 2'd0;   // row + 1
    localparam dir_t DIR_RIGHT = 2'd1;   // col + 1
    localparam dir_t DIR_UP    = 2'd2;   // row - 1
    localparam dir_t DIR_LEFT  = 2'd3;   // col - 1

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHK_START = 3'd1;
    localparam logic [2:0] ST_TRY       = 3'd2;
    localparam logic [2:0] ST_EVAL      = 3'd3;
    localparam logic [2:0] ST_POP       = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;
    localparam logic [2:0] ST_REPLAY    = 3'd7;

    // Opposite direction: flipping bit 1 swaps DOWN<->UP and RIGHT<->LEFT.
    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/maze_dfs_solver_if.sv
// Handshake/bus bundle of the maze DFS solver.
//   start, run, goal_row, goal_col  : control from the host
//   map_addr, map_we, map_rd_data   : external 1-bit-per-cell map port
//   busy, done, fail, overflow, path_len : status
//   move, move_valid, replay_done   : path replay stream
// master = host/map side, slave = solver side.
interface maze_dfs_solver_if #(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int STACK_DEPTH = 256
);
    import maze_dfs_solver_pkg::*;

    localparam int PL_W = $clog2(STACK_DEPTH) + 1;

    logic                   start;
    logic                   run;
    logic [ROW_W-1:0]       goal_row;
    logic [COL_W-1:0]       goal_col;
    logic [ROW_W+COL_W-1:0] map_addr;
    logic                   map_rd_data;
    logic                   map_we;
    logic                   busy;
    logic                   done;
    logic                   fail;
    logic                   overflow;
    logic [PL_W-1:0]        path_len;
    dir_t                   move;
    logic                   move_valid;
    logic                   replay_done;

    modport master (
        output start, run, goal_row, goal_col, map_rd_data,
        input  map_addr, map_we, busy, done, fail, overflow, path_len,
               move, move_valid, replay_done
    );

    modport slave (
        input  start, run, goal_row, goal_col, map_rd_data,
        output map_addr, map_we, busy, done, fail, overflow, path_len,
               move, move_valid, replay_done
    );

endinterface

// File: rtl/maze_dfs_solver_stack.sv
// maze_path_stack: LIFO of 2-bit direction entries holding the current path.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the stack)
//   clr_i           empty the stack
//   push_i, data_i  push one entry (never together with pop_i)
//   pop_i           drop the top entry
//   top_o           most recently pushed entry
//   full_o, empty_o occupancy flags
//   count_o         number of entries
//   rd_idx_i/rd_data_o  indexed read from the bottom (index 0) for replay
module maze_path_stack
    import maze_dfs_solver_pkg::*;
#(
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  dir_t          data_i,
    output dir_t          top_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    input  logic [AW-1:0] rd_idx_i,
    output dir_t          rd_data_o
);

    dir_t          mem_q [DEPTH];
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (push_i) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop_i) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: entries above the count are never observed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[cnt_q[AW-1:0]] <= data_i;
        end
    end

    assign top_o     = mem_q[cnt_q[AW-1:0] - AW'(1)];
    assign rd_data_o = mem_q[rd_idx_i];
    assign count_o   = cnt_q;
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/maze_dfs_solver.sv
// maze_dfs_solver: depth-first rat-in-maze solver from (0,0) to a runtime
// goal over an external 1-bit map (1 = wall/visited). The path lives in a
// LIFO and can be replayed one move per cycle after success.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   maze_dfs_solver_if.slave (control, map port, status, replay)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start after reset
// CHK_START | map read of (0,0) returning; mark it visited
// TRY       | present next in-bounds neighbour on the map, or give up
// EVAL      | neighbour read returning; advance into it or try next dir
// POP       | dead end: step back along the top entry
// DONE      | goal reached; run starts a replay, start a new search
// FAIL      | no path or stack overflow; start begins a new search
// REPLAY    | emitting path entries bottom to top, then replay_done
module maze_dfs_solver
    import maze_dfs_solver_pkg::*;
#(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int STACK_DEPTH = 256
) (
    input logic              clk,
    input logic              rst,
    maze_dfs_solver_if.slave bus
);

    localparam int AW   = ROW_W + COL_W;
    localparam int SAW  = $clog2(STACK_DEPTH);
    localparam int PL_W = SAW + 1;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [COL_W-1:0] COL_MAX = '1;

    logic [2:0]       state_q,    state_d;
    logic [ROW_W-1:0] cur_row_q,  cur_row_d;
    logic [COL_W-1:0] cur_col_q,  cur_col_d;
    logic [ROW_W-1:0] goal_row_q, goal_row_d;
    logic [COL_W-1:0] goal_col_q, goal_col_d;
    logic [2:0]       dir_q,      dir_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic [PL_W-1:0]  rp_idx_q,   rp_idx_d;
    logic             done_q,     done_d;
    logic             fail_q,     fail_d;
    logic             ovf_q,      ovf_d;

    logic             stk_clr, stk_push, stk_pop, stk_full, stk_empty;
    dir_t             stk_top, stk_rd_data;
    logic [PL_W-1:0]  stk_count;

    logic             map_we, move_valid, replay_done;
    logic             nbr_ok;
    logic [ROW_W-1:0] nbr_row, back_row;
    logic [COL_W-1:0] nbr_col, back_col;

    maze_path_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (stk_clr),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .data_i    (dir_q[1:0]),
        .top_o     (stk_top),
        .full_o    (stk_full),
        .empty_o   (stk_empty),
        .count_o   (stk_count),
        .rd_idx_i  (rp_idx_q[SAW-1:0]),
        .rd_data_o (stk_rd_data)
    );

    // Neighbour in the direction being tried; bounds are judged on the
    // current cell so the unsigned step never wraps into a legal cell.
    always_comb begin
        nbr_row = cur_row_q;
        nbr_col = cur_col_q;
        nbr_ok  = 1'b0;
        case (dir_q[1:0])
            DIR_DOWN: begin
                nbr_ok  = (cur_row_q != ROW_MAX);
                nbr_row = cur_row_q + ROW_W'(1);
            end
            DIR_RIGHT: begin
                nbr_ok  = (cur_col_q != COL_MAX);
                nbr_col = cur_col_q + COL_W'(1);
            end
            DIR_UP: begin
                nbr_ok  = (cur_row_q != '0);
                nbr_row = cur_row_q - ROW_W'(1);
            end
            default: begin
                nbr_ok  = (cur_col_q != '0);
                nbr_col = cur_col_q - COL_W'(1);
            end
        endcase
    end

    // Backtrack target: undo the move recorded on top of the stack.
    always_comb begin
        back_row = cur_row_q;
        back_col = cur_col_q;
        case (dir_reverse(stk_top))
            DIR_DOWN:  back_row = cur_row_q + ROW_W'(1);
            DIR_RIGHT: back_col = cur_col_q + COL_W'(1);
            DIR_UP:    back_row = cur_row_q - ROW_W'(1);
            default:   back_col = cur_col_q - COL_W'(1);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        goal_row_d  = goal_row_q;
        goal_col_d  = goal_col_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        rp_idx_d    = rp_idx_q;
        done_d      = done_q;
        fail_d      = fail_q;
        ovf_d       = ovf_q;
        stk_clr     = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        map_we      = 1'b0;
        move_valid  = 1'b0;
        replay_done = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.start) begin
                    goal_row_d = bus.goal_row;
                    goal_col_d = bus.goal_col;
                    cur_row_d  = '0;
                    cur_col_d  = '0;
                    dir_d      = '0;
                    addr_d     = '0;
                    stk_clr    = 1'b1;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = ST_CHK_START;
                end else if (state_q == ST_DONE && bus.run) begin
                    rp_idx_d = '0;
                    state_d  = ST_REPLAY;
                end
            end

            ST_CHK_START: begin
                if (bus.map_rd_data) begin
                    fail_d  = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    map_we = 1'b1;
                    if (cur_row_q == goal_row_q && cur_col_q == goal_col_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TRY;
                    end
                end
            end

            ST_TRY: begin
                if (dir_q[2]) begin
                    state_d = ST_POP;
                end else if (nbr_ok) begin
                    addr_d  = {nbr_row, nbr_col};
                    state_d = ST_EVAL;
                end else begin
                    dir_d = dir_q + 3'd1;
                end
            end

            ST_EVAL: begin
                if (bus.map_rd_data) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = ST_TRY;
                end else if (stk_full) begin
                    ovf_d   = 1'b1;
                    fail_d  = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    // addr_q still holds the neighbour, so the mark lands there.
                    map_we    = 1'b1;
                    stk_push  = 1'b1;
                    cur_row_d = nbr_row;
                    cur_col_d = nbr_col;
                    dir_d     = '0;
                    if (nbr_row == goal_row_q && nbr_col == goal_col_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TRY;
                    end
                end
            end

            ST_POP: begin
                if (stk_empty) begin
                    fail_d  = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    stk_pop   = 1'b1;
                    cur_row_d = back_row;
                    cur_col_d = back_col;
                    dir_d     = {1'b0, stk_top} + 3'd1;
                    state_d   = ST_TRY;
                end
            end

            default: begin // ST_REPLAY
                if (rp_idx_q < stk_count) begin
                    move_valid = 1'b1;
                    rp_idx_d   = rp_idx_q + PL_W'(1);
                end else begin
                    replay_done = 1'b1;
                    state_d     = ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            goal_row_q <= '0;
            goal_col_q <= '0;
            dir_q      <= '0;
            addr_q     <= '0;
            rp_idx_q   <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            goal_row_q <= goal_row_d;
            goal_col_q <= goal_col_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            rp_idx_q   <= rp_idx_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
        end
    end

    // The map address leaves ahead of its register so the external map,
    // which answers one cycle later, returns the cell in the following state.
    assign bus.map_addr    = rst ? '0 : addr_d;
    assign bus.map_we      = map_we;
    assign bus.busy        = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
    assign bus.done        = done_q;
    assign bus.fail        = fail_q;
    assign bus.overflow    = ovf_q;
    assign bus.path_len    = stk_count;
    assign bus.move        = move_valid ? stk_rd_data : DIR_DOWN;
    assign bus.move_valid  = move_valid;
    assign bus.replay_done = replay_done;

endmodule

// File: tb/tb_maze_dfs_solver.sv
module tb_maze_dfs_solver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maze_dfs_solver_if #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(16)) bus_a ();
    maze_dfs_solver_if #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(4))  bus_b ();

    maze_dfs_solver #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(16)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    maze_dfs_solver #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Behavioural maps: 1-cycle read latency, write-1 on map_we, bulk load.
    logic [15:0] mem_a, mem_b, load_val_a, load_val_b;
    logic        load_a, load_b, rd_a, rd_b;

    always @(posedge clk) begin
        rd_a <= mem_a[bus_a.map_addr];
        if (load_a)            mem_a <= load_val_a;
        else if (bus_a.map_we) mem_a[bus_a.map_addr] <= 1'b1;
    end

    always @(posedge clk) begin
        rd_b <= mem_b[bus_b.map_addr];
        if (load_b)            mem_b <= load_val_b;
        else if (bus_b.map_we) mem_b[bus_b.map_addr] <= 1'b1;
    end

    assign bus_a.map_rd_data = rd_a;
    assign bus_b.map_rd_data = rd_b;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] walls;
        logic [1:0]  grow;
        logic [1:0]  gcol;
        logic        exp_done;
        logic        exp_fail;
        logic        exp_ovf;
        int          exp_len;
        logic [31:0] exp_moves;   // entry k at bits [2k+1:2k]
        int          max_cyc;
        logic        chk_map;
        logic [15:0] exp_map;
    } vec_t;

    vec_t vecs [6];

    task automatic load_map_a(input logic [15:0] v);
        @(negedge clk);
        load_val_a = v;
        load_a     = 1'b1;
        @(negedge clk);
        load_a     = 1'b0;
    endtask

    task automatic start_a(input logic [1:0] gr, input logic [1:0] gc);
        bus_a.goal_row = gr;
        bus_a.goal_col = gc;
        bus_a.start    = 1'b1;
        @(negedge clk);
        bus_a.start    = 1'b0;
    endtask

    task automatic replay_a(input string tag, input int len, input logic [31:0] moves);
        int k = 0;
        int cyc = 0;
        logic [31:0] mv;
        bus_a.run = 1'b1;
        @(negedge clk);
        bus_a.run = 1'b0;
        while (!bus_a.replay_done && cyc < 40) begin
            if (bus_a.move_valid && k < 16) begin
                mv = moves >> (2 * k);
                chk($sformatf("%s move[%0d]", tag, k), {30'd0, bus_a.move}, {30'd0, mv[1:0]});
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " replay_done seen"}, {31'd0, bus_a.replay_done}, 32'd1);
        chk({tag, " replay count"}, k, len);
        @(negedge clk);
        chk({tag, " done after replay"}, {31'd0, bus_a.done}, 32'd1);
        chk({tag, " replay_done one cycle"}, {31'd0, bus_a.replay_done}, 32'd0);
        chk({tag, " busy after replay"}, {31'd0, bus_a.busy}, 32'd0);
    endtask

    initial begin
        // walls, goal, done, fail, ovf, len, moves, max cycles, map check, final map
        vecs[0] = '{16'h0000, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 6, 32'h0000_0540, 400, 1'b0, 16'h0000};
        vecs[1] = '{16'h0001, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0000, 3,   1'b1, 16'h0001};
        vecs[2] = '{16'h2220, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 6, 32'h0000_0405, 400, 1'b0, 16'h0000};
        vecs[3] = '{16'h4800, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0000, 400, 1'b1, 16'h7FFF};
        vecs[4] = '{16'h0000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 9, 32'h0002_A540, 400, 1'b0, 16'h0000};
        vecs[5] = '{16'h0000, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2, 32'h0000_0000, 400, 1'b0, 16'h0000};

        load_a = 1'b0; load_b = 1'b0;
        load_val_a = '0; load_val_b = '0;
        bus_a.start = 1'b0; bus_a.run = 1'b0; bus_a.goal_row = '0; bus_a.goal_col = '0;
        bus_b.start = 1'b0; bus_b.run = 1'b0; bus_b.goal_row = '0; bus_b.goal_col = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset busy",       {31'd0, bus_a.busy}, 32'd0);
        chk("reset done",       {31'd0, bus_a.done}, 32'd0);
        chk("reset fail",       {31'd0, bus_a.fail}, 32'd0);
        chk("reset overflow",   {31'd0, bus_a.overflow}, 32'd0);
        chk("reset path_len",   {27'd0, bus_a.path_len}, 32'd0);
        chk("reset map_addr",   {28'd0, bus_a.map_addr}, 32'd0);
        chk("reset map_we",     {31'd0, bus_a.map_we}, 32'd0);
        chk("reset move_valid", {31'd0, bus_a.move_valid}, 32'd0);
        chk("reset replay_done",{31'd0, bus_a.replay_done}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            int cyc;
            string tag;
            tag = $sformatf("vec%0d", i);
            load_map_a(vecs[i].walls);
            start_a(vecs[i].grow, vecs[i].gcol);
            cyc = 1;
            while (!(bus_a.done || bus_a.fail) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk({tag, " finished"},   {31'd0, bus_a.done | bus_a.fail}, 32'd1);
            chk({tag, " within bound"}, {31'd0, cyc <= vecs[i].max_cyc}, 32'd1);
            chk({tag, " done"},       {31'd0, bus_a.done}, {31'd0, vecs[i].exp_done});
            chk({tag, " fail"},       {31'd0, bus_a.fail}, {31'd0, vecs[i].exp_fail});
            chk({tag, " overflow"},   {31'd0, bus_a.overflow}, {31'd0, vecs[i].exp_ovf});
            chk({tag, " path_len"},   {27'd0, bus_a.path_len}, vecs[i].exp_len);
            chk({tag, " busy"},       {31'd0, bus_a.busy}, 32'd0);
            if (vecs[i].chk_map) begin
                @(negedge clk);
                chk({tag, " map"}, {16'd0, mem_a}, {16'd0, vecs[i].exp_map});
            end
            if (vecs[i].exp_done) begin
                replay_a(tag, vecs[i].exp_len, vecs[i].exp_moves);
            end
        end

        // Shallow stack: open map overruns a 4-entry path.
        begin
            int cyc = 1;
            @(negedge clk);
            load_val_b = 16'h0000;
            load_b     = 1'b1;
            @(negedge clk);
            load_b         = 1'b0;
            bus_b.goal_row = 2'd3;
            bus_b.goal_col = 2'd3;
            bus_b.start    = 1'b1;
            @(negedge clk);
            bus_b.start    = 1'b0;
            while (!(bus_b.done || bus_b.fail) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk("ovf finished", {31'd0, bus_b.done | bus_b.fail}, 32'd1);
            chk("ovf fail",     {31'd0, bus_b.fail}, 32'd1);
            chk("ovf done",     {31'd0, bus_b.done}, 32'd0);
            chk("ovf overflow", {31'd0, bus_b.overflow}, 32'd1);
            chk("ovf path_len", {29'd0, bus_b.path_len}, 32'd4);
        end

        // Reset mid-search, then goal at the origin.
        load_map_a(16'h0000);
        start_a(2'd3, 2'd3);
        repeat (4) @(negedge clk);
        chk("mid busy before rst", {31'd0, bus_a.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy",     {31'd0, bus_a.busy}, 32'd0);
        chk("rst done",     {31'd0, bus_a.done}, 32'd0);
        chk("rst fail",     {31'd0, bus_a.fail}, 32'd0);
        chk("rst path_len", {27'd0, bus_a.path_len}, 32'd0);
        chk("rst map_addr", {28'd0, bus_a.map_addr}, 32'd0);
        load_map_a(16'h0000);
        start_a(2'd0, 2'd0);
        chk("origin busy in chk_start", {31'd0, bus_a.busy}, 32'd1);
        chk("origin map_we",            {31'd0, bus_a.map_we}, 32'd1);
        @(negedge clk);
        chk("origin done",     {31'd0, bus_a.done}, 32'd1);
        chk("origin fail",     {31'd0, bus_a.fail}, 32'd0);
        chk("origin path_len", {27'd0, bus_a.path_len}, 32'd0);
        bus_a.run = 1'b1;
        @(negedge clk);
        bus_a.run = 1'b0;
        chk("origin replay_done", {31'd0, bus_a.replay_done}, 32'd1);
        chk("origin move_valid",  {31'd0, bus_a.move_valid}, 32'd0);
        @(negedge clk);
        chk("origin replay_done pulse", {31'd0, bus_a.replay_done}, 32'd0);
        chk("origin done hold",         {31'd0, bus_a.done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
